fir_decim_fifo: RTL and testbench
=================================

FIR_DECIM_FIFO -- requirements
Module: fir_decim_fifo

Interface
REQ-001 Parameter WIDTH, default 24, is the signed sample width in bits for input and output.
REQ-002 Parameter DECIM, default 4, is the decimation ratio; it SHALL be a power of two, at least 2.
REQ-003 Parameter DEPTH, default 8, is the output FIFO depth in entries; it SHALL be a power of two, at least 2.
REQ-004 clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_sig  input  WIDTH  signed filtered sample from the upstream FIR stage.
REQ-007 in_ready  input  1  sample strobe; each cycle it is high delivers one in_sig sample.
REQ-008 out_sig  output  WIDTH  signed FIFO head sample.
REQ-009 out_valid  output  1  high while the FIFO is non-empty.
REQ-010 out_ack  input  1  consumer pop; acts only when out_valid is high.
REQ-011 level  output  clog2(DEPTH)+1  current FIFO occupancy.
REQ-012 overflow  output  1  sticky flag; set when a decimated sample is dropped.

Function
REQ-013 A phase counter, range 0..DECIM-1, SHALL increment on every cycle with in_ready high and wrap from DECIM-1 to 0.
REQ-014 A decimated sample SHALL be produced in the in_ready cycle where the phase equals DECIM-1; no sample is produced in any other cycle.
REQ-015 Without averaging, the decimated sample SHALL equal in_sig in that cycle.
REQ-016 A produced sample SHALL be written on that clock edge; out_valid and out_sig SHALL reflect it in the next cycle, for a latency of 1 clock when the FIFO was empty.
REQ-017 The FIFO SHALL be first-word-fall-through: out_sig always presents the oldest entry while out_valid is high.
REQ-018 A pop SHALL occur when out_valid and out_ack are both high; out_ack while empty SHALL change no state.
REQ-019 Push when not full SHALL increment level; a pop alone SHALL decrement level; a push and a pop in the same cycle SHALL both complete with level unchanged.
REQ-020 A push when full with no pop in the same cycle SHALL drop the sample, set overflow, and leave FIFO contents and level unchanged.
REQ-021 A push when full with a pop in the same cycle SHALL be accepted, and SHALL NOT set overflow.
REQ-022 The read and write pointers SHALL wrap modulo DEPTH; full is level==DEPTH and empty is level==0.
REQ-023 overflow SHALL remain set until rst.

Reset
REQ-024 On rst high at a clock edge the block SHALL clear the phase, the accumulator, the pointers, level, and overflow, and set out_valid to 0 and out_sig to 0.
REQ-025 rst SHALL take priority over a simultaneous in_ready or out_ack, and any partial decimation group SHALL be discarded.

Configuration
REQ-026 With macro FIR_DECIM_AVG_EN defined, the decimated sample SHALL be the sum of the DECIM samples in the group, held in a WIDTH+log2(DECIM)-bit accumulator, arithmetically shifted right by log2(DECIM) (floor rounding); the accumulator SHALL restart with the sample at phase 0.
REQ-027 Without FIR_DECIM_AVG_EN, no accumulator SHALL exist and REQ-015 SHALL apply.

Structure
REQ-028 A shared package fir_pkg SHALL hold the default WIDTH, DECIM, and DEPTH constants and the signed sample typedef sample_t.
REQ-029 The FIFO SHALL be a sub-module named sample_fifo (parameters WIDTH and DEPTH) instantiated inside fir_decim_fifo; the phase counter and the accumulator SHALL reside in the top module.

Verification (WIDTH=24, DECIM=4, DEPTH=8)
REQ-030 Reset: assert rst for 2 cycles -> out_valid=0, level=0, overflow=0, out_sig=0.
REQ-031 Four strobes with values 10, 20, 30, 40 -> one entry; out_valid rises the cycle after the 4th strobe; out_sig=40 without averaging and 25 with FIR_DECIM_AVG_EN.
REQ-032 Four strobes with values -1, -2, -3, -4 -> out_sig=-4 without averaging and -3 with FIR_DECIM_AVG_EN.
REQ-033 Overflow: hold out_ack=0 and send 36 strobes -> level=8, overflow=1, and the 9th group is absent on readout; then, when full, a 10th group plus out_ack in the same cycle -> level stays 8 and no new drop occurs.
REQ-034 Reset mid-group: 2 strobes, then rst, then strobes 1, 2, 3, 4 -> exactly one entry, with out_sig=4 (or 2 with FIR_DECIM_AVG_EN).
REQ-035 Pulse out_ack while empty -> level=0, out_valid=0, and no pointer change.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared defaults and sample type for the decimating FIR output stage.
package fir_pkg;
    localparam int unsigned DEF_WIDTH = 24;
    localparam int unsigned DEF_DECIM = 4;
    localparam int unsigned DEF_DEPTH = 8;

    typedef logic signed [DEF_WIDTH-1:0] sample_t;
endpackage

// File: rtl/sample_fifo.sv
// First-word-fall-through sample FIFO with occupancy count and sticky drop flag.
module sample_fifo #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic signed [WIDTH-1:0]   wr_data,
    input  logic                      pop_req,
    output logic signed [WIDTH-1:0]   rd_data,
    output logic                      valid,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      overflow
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [AW-1:0]           wr_ptr;
    logic [AW-1:0]           rd_ptr;
    logic signed [WIDTH-1:0] mem [DEPTH];
    logic                    pop_c;
    logic                    full_c;
    logic                    wr_c;
    logic                    drop_c;

    // A push into a full FIFO is only accepted when a pop frees the slot in the same cycle.
    assign pop_c  = pop_req && (level != '0);
    assign full_c = (level == LW'(DEPTH));
    assign wr_c   = push && (!full_c || pop_c);
    assign drop_c = push && full_c && !pop_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_c)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop_c)
                rd_ptr <= rd_ptr + AW'(1);
            case ({wr_c, pop_c})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
            if (drop_c)
                overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_c)
            mem[wr_ptr] <= wr_data;
    end

    assign valid   = (level != '0);
    assign rd_data = valid ? mem[rd_ptr] : '0;
endmodule

// File: rtl/fir_decim_fifo.sv
// Decimates the FIR sample stream by DECIM and queues results in a FWFT FIFO.
// Define FIR_DECIM_AVG_EN to output the floor-average of each group instead of its last sample.
module fir_decim_fifo
    import fir_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DECIM = DEF_DECIM,
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic signed [WIDTH-1:0]   in_sig,
    input  logic                      in_ready,
    output logic signed [WIDTH-1:0]   out_sig,
    output logic                      out_valid,
    input  logic                      out_ack,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      overflow
);
    localparam int unsigned PW = $clog2(DECIM);

    logic [PW-1:0]           phase;
    logic                    push_c;
    logic signed [WIDTH-1:0] sample_c;

    always_ff @(posedge clk) begin
        if (rst)
            phase <= '0;
        else if (in_ready)
            phase <= (phase == PW'(DECIM - 1)) ? '0 : phase + PW'(1);
    end

    assign push_c = in_ready && (phase == PW'(DECIM - 1));

`ifdef FIR_DECIM_AVG_EN
    localparam int unsigned AW = WIDTH + PW;

    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] acc_next_c;

    // Phase 0 restarts the sum so the closing sample sees the full group in acc_next_c.
    always_comb begin
        acc_next_c = AW'(in_sig);
        if (phase != '0)
            acc_next_c = acc + AW'(in_sig);
    end

    always_ff @(posedge clk) begin
        if (rst)
            acc <= '0;
        else if (in_ready)
            acc <= acc_next_c;
    end

    assign sample_c = WIDTH'(acc_next_c >>> PW);
`else
    assign sample_c = in_sig;
`endif

    sample_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push_c),
        .wr_data  (sample_c),
        .pop_req  (out_ack),
        .rd_data  (out_sig),
        .valid    (out_valid),
        .level    (level),
        .overflow (overflow)
    );
endmodule

// File: tb/tb_fir_decim_fifo.sv
// Scoreboard bench for fir_decim_fifo; expected samples are queued as groups complete.
module tb_fir_decim_fifo;
    localparam int unsigned WIDTH = 24;
    localparam int unsigned DECIM = 4;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned LOGD  = 2;

`ifdef FIR_DECIM_AVG_EN
    localparam longint E_POS = 25;
    localparam longint E_NEG = -3;
    localparam longint E_RST = 2;
`else
    localparam longint E_POS = 40;
    localparam longint E_NEG = -4;
    localparam longint E_RST = 4;
`endif

    logic                    clk = 1'b0;
    logic                    rst;
    logic signed [WIDTH-1:0] in_sig;
    logic                    in_ready;
    logic signed [WIDTH-1:0] out_sig;
    logic                    out_valid;
    logic                    out_ack;
    logic [3:0]              level;
    logic                    overflow;

    int     n_checks = 0;
    int     n_errors = 0;
    longint mq[$];
    int     m_phase = 0;
    longint m_acc = 0;
    logic   m_ovf = 1'b0;

    fir_decim_fifo #(.WIDTH(WIDTH), .DECIM(DECIM), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_sig    (in_sig),
        .in_ready  (in_ready),
        .out_sig   (out_sig),
        .out_valid (out_valid),
        .out_ack   (out_ack),
        .level     (level),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // One cycle: compare outputs with the model, then apply inputs and advance the model.
    task automatic drive(input logic r, input logic rdy, input int val, input logic ack);
        longint smp;
        longint tmp;
        logic   popped;
        logic   full;
        @(negedge clk);
        chk("valid", out_valid, mq.size() != 0);
        chk("level", level, mq.size());
        chk("overflow", overflow, m_ovf);
        if (mq.size() != 0)
            chk("head", out_sig, mq[0]);
        rst      = r;
        in_ready = rdy;
        in_sig   = WIDTH'(val);
        out_ack  = ack;
        if (r) begin
            mq.delete();
            m_phase = 0;
            m_acc   = 0;
            m_ovf   = 1'b0;
        end else begin
            popped = ack && (mq.size() != 0);
            full   = (mq.size() == DEPTH);
            if (popped)
                tmp = mq.pop_front();
            if (rdy) begin
                if (m_phase == 0)
                    m_acc = val;
                else
                    m_acc = m_acc + val;
                if (m_phase == DECIM - 1) begin
`ifdef FIR_DECIM_AVG_EN
                    smp = m_acc >>> LOGD;
`else
                    smp = val;
`endif
                    if (full && !popped)
                        m_ovf = 1'b1;
                    else
                        mq.push_back(smp);
                end
                m_phase = (m_phase + 1) % DECIM;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            drive(1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic drain();
        while (mq.size() != 0)
            drive(1'b0, 1'b0, 0, 1'b1);
        idle(1);
    endtask

    initial begin
        // Reset held two cycles while strobe and ack are also high.
        rst = 1'b1; in_ready = 1'b1; in_sig = WIDTH'(7); out_ack = 1'b1;
        repeat (2) @(posedge clk);
        idle(1);
        chk("rst_valid", out_valid, 0);
        chk("rst_level", level, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_out_sig", out_sig, 0);

        // Positive group and one-cycle latency.
        drive(1'b0, 1'b1, 10, 1'b0);
        drive(1'b0, 1'b1, 20, 1'b0);
        drive(1'b0, 1'b1, 30, 1'b0);
        drive(1'b0, 1'b1, 40, 1'b0);
        chk("lat_before", out_valid, 0);
        idle(1);
        chk("lat_after", out_valid, 1);
        chk("pos_group", out_sig, E_POS);
        chk("pos_level", level, 1);
        drain();

        // Negative group exercises sign handling and floor rounding.
        for (int i = 1; i <= 4; i++)
            drive(1'b0, 1'b1, -i, 1'b0);
        idle(1);
        chk("neg_group", out_sig, E_NEG);
        drain();

        // Fill to full and drop the 9th group.
        for (int g = 1; g <= 9; g++)
            for (int i = 0; i < 4; i++)
                drive(1'b0, 1'b1, 100 * g + i, 1'b0);
        idle(1);
        chk("full_level", level, 8);
        chk("full_ovf", overflow, 1);
        chk("full_head", out_sig, mq[0]);
        // 10th group closes in the same cycle as a pop.
        for (int i = 0; i < 3; i++)
            drive(1'b0, 1'b1, 1000 + i, 1'b0);
        drive(1'b0, 1'b1, 1003, 1'b1);
        idle(1);
        chk("full_pushpop_level", level, 8);
        chk("full_pushpop_len", mq.size(), 8);
        drain();
        chk("ovf_sticky", overflow, 1);

        // Reset in the middle of a group discards the partial group.
        drive(1'b0, 1'b1, 50, 1'b0);
        drive(1'b0, 1'b1, 60, 1'b0);
        drive(1'b1, 1'b1, 70, 1'b1);
        for (int i = 1; i <= 4; i++)
            drive(1'b0, 1'b1, i, 1'b0);
        idle(1);
        chk("midrst_level", level, 1);
        chk("midrst_sig", out_sig, E_RST);
        chk("midrst_ovf", overflow, 0);
        drain();

        // Acks while empty must do nothing.
        for (int i = 0; i < 3; i++)
            drive(1'b0, 1'b0, 0, 1'b1);
        idle(1);
        chk("empty_ack_level", level, 0);
        chk("empty_ack_valid", out_valid, 0);
        for (int i = 0; i < 4; i++)
            drive(1'b0, 1'b1, 7 * i - 5, 1'b0);
        // Push and pop together with one entry present keeps level at 1.
        for (int i = 0; i < 3; i++)
            drive(1'b0, 1'b1, 11 * i, 1'b0);
        drive(1'b0, 1'b1, 99, 1'b1);
        idle(1);
        chk("pushpop_level", level, 1);
        drain();

        // Random traffic across the full signed range.
        for (int i = 0; i < 400; i++)
            drive(1'b0, 1'($urandom_range(0, 3) != 0),
                  int'($urandom_range(0, 32'hFF_FFFF)) - 32'sh80_0000,
                  1'($urandom_range(0, 2) == 0));
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
